// File: rtl/pipeid_scoreboard.sv
// Decode-stage hazard/forwarding unit: a shift-register scoreboard of in-flight
// register writers drives per-operand forwarding selects and a load-use stall.
module pipeid_scoreboard #(
  parameter int AW         = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16,
  localparam int DW        = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [AW-1:0]    id_rn,
  input  logic             flush,
  output logic             stall,
  output logic [DW-1:0]    a_depen,
  output logic [DW-1:0]    b_depen,
  output logic             sb_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [STAGES:1] v;
  logic [STAGES:1] ld;
  logic [AW-1:0]   rn [1:STAGES];

  logic a_ld, b_ld, hazard, ins;

  // Scan oldest to youngest so the lowest matching stage overrides older ones.
  always_comb begin
    a_depen = '0;
    b_depen = '0;
    a_ld    = 1'b0;
    b_ld    = 1'b0;
    for (int unsigned k = STAGES; k >= 1; k--) begin
      if (v[k] && rn[k] == id_rs && id_rs != '0 && id_use_rs && id_valid) begin
        a_depen = DW'(k);
        a_ld    = ld[k];
      end
      if (v[k] && rn[k] == id_rt && id_rt != '0 && id_use_rt && id_valid) begin
        b_depen = DW'(k);
        b_ld    = ld[k];
      end
    end
  end

  always_comb begin
    hazard  = (a_ld && a_depen < DW'(LOAD_READY)) || (b_ld && b_depen < DW'(LOAD_READY));
    stall   = hazard && !flush;
    ins     = id_valid && id_wreg && id_rn != '0 && !stall && !flush;
    sb_busy = |v;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v         <= '0;
      ld        <= '0;
      stall_cnt <= '0;
      for (int unsigned k = 1; k <= STAGES; k++) rn[k] <= '0;
    end else begin
      for (int unsigned k = 2; k <= STAGES; k++) begin
        v[k]  <= v[k-1];
        ld[k] <= ld[k-1];
        rn[k] <= rn[k-1];
      end
      v[1]  <= ins;
      ld[1] <= ins && id_m2reg;
      rn[1] <= ins ? id_rn : '0;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeid_scoreboard.sv
// Directed bench for pipeid_scoreboard: forwarding distance, load-use stall,
// youngest-wins, r0/unused operands, flush, counter saturation and async reset.
module tb_pipeid_scoreboard;

  logic       clk = 1'b0;
  logic       clrn;
  logic       id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, flush;
  logic [4:0] id_rs, id_rt, id_rn;

  logic        stall1, busy1, stall2, busy2;
  logic [1:0]  a1, b1, a2, b2;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  pipeid_scoreboard #(.AW(5), .STAGES(3), .LOAD_READY(2), .CNT_W(16)) dut (
    .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_rn(id_rn), .flush(flush), .stall(stall1),
    .a_depen(a1), .b_depen(b1), .sb_busy(busy1), .stall_cnt(cnt1)
  );

  // Narrow counter copy sharing the same stimulus, used for saturation.
  pipeid_scoreboard #(.AW(5), .STAGES(3), .LOAD_READY(2), .CNT_W(2)) dut_sat (
    .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_rn(id_rn), .flush(flush), .stall(stall2),
    .a_depen(a2), .b_depen(b2), .sb_busy(busy2), .stall_cnt(cnt2)
  );

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic vld, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt, input logic wr,
                        input logic ldi, input logic [4:0] rd, input logic fl);
    id_valid  = vld;
    id_rs     = rs;
    id_use_rs = urs;
    id_rt     = rt;
    id_use_rt = urt;
    id_wreg   = wr;
    id_m2reg  = ldi;
    id_rn     = rd;
    flush     = fl;
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clrn = 1'b0;
    nop();
    #11 clrn = 1'b1;
    check_val("rst_stall", stall1, 0);
    check_val("rst_a", a1, 0);
    check_val("rst_b", b1, 0);
    check_val("rst_busy", busy1, 0);
    check_val("rst_cnt", cnt1, 0);

    // ALU forwarding distance: add r3, then reader at 0/1/2/3 intervening nops
    set_id(1, 5'd1, 1, 5'd2, 1, 1, 0, 5'd3, 0); tick();
    set_id(1, 5'd3, 1, 5'd0, 0, 0, 0, 5'd0, 0);
    check_val("alu_d1_a", a1, 1);
    check_val("alu_d1_stall", stall1, 0);
    check_val("alu_busy", busy1, 1);
    nop(); tick();
    set_id(1, 5'd3, 1, 5'd0, 0, 0, 0, 5'd0, 0);
    check_val("alu_d2_a", a1, 2);
    nop(); tick();
    set_id(1, 5'd3, 1, 5'd0, 0, 0, 0, 5'd0, 0);
    check_val("alu_d3_a", a1, 3);
    nop(); tick();
    set_id(1, 5'd3, 1, 5'd0, 0, 0, 0, 5'd0, 0);
    check_val("alu_d4_a", a1, 0);
    check_val("alu_d4_busy", busy1, 0);

    // Load-use: lw r5; add r7 <- r6, r5
    set_id(1, 5'd1, 1, 5'd0, 0, 1, 1, 5'd5, 0); tick();
    set_id(1, 5'd6, 1, 5'd5, 1, 1, 0, 5'd7, 0);
    check_val("lu_stall", stall1, 1);
    check_val("lu_b_ex", b1, 1);
    check_val("lu_a", a1, 0);
    tick();
    check_val("lu_stall_clr", stall1, 0);
    check_val("lu_b_mem", b1, 2);
    check_val("lu_cnt", cnt1, 1);
    tick();
    set_id(1, 5'd7, 1, 5'd5, 1, 0, 0, 5'd0, 0);
    check_val("lu_after_a", a1, 1);
    check_val("lu_after_b", b1, 3);
    nop(); tick(); tick(); tick();

    // Youngest wins: lw r4, nop, add r4 -> load at stage 3, ALU at stage 1
    set_id(1, 5'd0, 0, 5'd0, 0, 1, 1, 5'd4, 0); tick();
    nop(); tick();
    set_id(1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd4, 0); tick();
    set_id(1, 5'd4, 1, 5'd0, 0, 0, 0, 5'd0, 0);
    check_val("yw_a", a1, 1);
    check_val("yw_stall", stall1, 0);
    nop(); tick(); tick(); tick();

    // r0 never tracked; unused operand never matches
    set_id(1, 5'd0, 0, 5'd0, 0, 1, 1, 5'd0, 0); tick();
    check_val("r0_busy", busy1, 0);
    set_id(1, 5'd0, 1, 5'd0, 1, 0, 0, 5'd0, 0);
    check_val("r0_a", a1, 0);
    check_val("r0_b", b1, 0);
    set_id(1, 5'd0, 0, 5'd0, 0, 1, 1, 5'd9, 0); tick();
    set_id(1, 5'd9, 0, 5'd0, 0, 0, 0, 5'd0, 0);
    check_val("unused_stall", stall1, 0);
    check_val("unused_a", a1, 0);
    nop(); tick(); tick(); tick();

    // Flush beats the load hazard: no stall, flushed writer not inserted
    set_id(1, 5'd0, 0, 5'd0, 0, 1, 1, 5'd8, 0); tick();
    set_id(1, 5'd0, 0, 5'd8, 1, 1, 0, 5'd10, 1);
    check_val("fl_stall", stall1, 0);
    check_val("fl_b", b1, 1);
    tick();
    set_id(1, 5'd10, 1, 5'd8, 1, 0, 0, 5'd0, 0);
    check_val("fl_cnt", cnt1, 1);
    check_val("fl_bubble_a", a1, 0);
    check_val("fl_b_mem", b1, 2);
    check_val("fl_no_stall", stall1, 0);
    nop(); tick(); tick(); tick();

    // Three more load-use stalls: narrow counter goes 2, 3, then holds at 3
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'd0, 0, 5'd0, 0, 1, 1, 5'(11 + i), 0); tick();
      set_id(1, 5'(11 + i), 1, 5'd0, 0, 0, 0, 5'd0, 0);
      check_val("sat_stall", stall2, 1);
      tick();
      check_val("sat_cnt2", cnt2, (i == 0) ? 2 : 3);
    end
    check_val("sat_cnt1", cnt1, 4);
    nop();
    check_val("pre_rst_busy", busy1, 1);

    // Async reset away from any clock edge
    #2 clrn = 1'b0;
    #1;
    check_val("arst_busy", busy1, 0);
    check_val("arst_busy2", busy2, 0);
    check_val("arst_cnt", cnt1, 0);
    check_val("arst_cnt2", cnt2, 0);
    clrn = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
